// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU datapath and the
// debug/loader port with starvation-bounded ownership.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  owner_t            owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rd_pend_cpu_q;
  logic              rd_pend_dbg_q;
  logic              cpu_win, dbg_win;
  logic              both;
  acc_t              cpu_acc, dbg_acc, win_acc;

  assign both = cpu_req & dbg_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q       <= OWN_CPU;
      hold_q        <= '0;
      rd_pend_cpu_q <= 1'b0;
      rd_pend_dbg_q <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      hold_q        <= hold_d;
      rd_pend_cpu_q <= cpu_gnt & ~cpu_we;
      rd_pend_dbg_q <= dbg_gnt & ~dbg_we;
    end
  end

  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    owner_d = owner_q;
    hold_d  = hold_q;
    unique case (1'b1)
      (cpu_req & ~dbg_req): begin
        cpu_win = 1'b1;
        owner_d = OWN_CPU;
        hold_d  = '0;
      end
      (dbg_req & ~cpu_req): begin
        dbg_win = 1'b1;
        owner_d = OWN_DBG;
        hold_d  = '0;
      end
      (both & (hold_q < HOLD_MAX)): begin
        cpu_win = (owner_q == OWN_CPU);
        dbg_win = (owner_q == OWN_DBG);
        hold_d  = hold_q + HOLD_ONE;
      end
      (both & (hold_q >= HOLD_MAX)): begin
        // owner has used its quota; hand over to the waiting port
        cpu_win = (owner_q == OWN_DBG);
        dbg_win = (owner_q == OWN_CPU);
        owner_d = (owner_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
        hold_d  = HOLD_ONE;
      end
      default: ;
    endcase
  end

  // grants are forced low while reset is held, even with requests up
  assign cpu_gnt   = cpu_win & rst;
  assign dbg_gnt   = dbg_win & rst;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign cpu_acc = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dbg_acc = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
  assign win_acc = dbg_gnt ? dbg_acc : cpu_acc;

  assign mem_en    = cpu_gnt | dbg_gnt;
  assign mem_we    = mem_en & win_acc.we;
  assign mem_addr  = win_acc.addr;
  assign mem_wdata = win_acc.wdata;

  assign cpu_rvalid = rd_pend_cpu_q;
  assign dbg_rvalid = rd_pend_dbg_q;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant, ownership, read return
// and reset behaviour of mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        u1_cpu_gnt, u1_cpu_rvalid, u1_cpu_stall;
  logic [31:0] u1_cpu_rdata;
  logic        u1_dbg_gnt, u1_dbg_rvalid;
  logic [31:0] u1_dbg_rdata;
  logic        u1_mem_en, u1_mem_we;
  logic [31:0] u1_mem_addr, u1_mem_wdata;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(1)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(u1_cpu_gnt), .cpu_rvalid(u1_cpu_rvalid),
    .cpu_rdata(u1_cpu_rdata), .cpu_stall(u1_cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(u1_dbg_gnt), .dbg_rvalid(u1_dbg_rvalid),
    .dbg_rdata(u1_dbg_rdata),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we),
    .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // behavioural memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'h1234_5678;

    // outputs held low in reset even with both requests raised
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    #12;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // single cpu read
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("rd_cpu_gnt", cpu_gnt, 1);
    chk("rd_dbg_gnt", dbg_gnt, 0);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_cpu_stall", cpu_stall, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_cpu_rvalid", cpu_rvalid, 1);
    chk("rd_cpu_rdata", cpu_rdata, 32'h1234_5678);
    chk("rd_dbg_rvalid", dbg_rvalid, 0);
    chk("idle_mem_en", mem_en, 0);

    // debug write then cpu read-back
    drive(0, 0, 0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF);
    chk("wr_dbg_gnt", dbg_gnt, 1);
    chk("wr_cpu_gnt", cpu_gnt, 0);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h40);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
    chk("wr_dbg_rvalid", dbg_rvalid, 0);
    chk("wr_cpu_rvalid", cpu_rvalid, 0);
    chk("rb_cpu_gnt", cpu_gnt, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rb_cpu_rvalid", cpu_rvalid, 1);
    chk("rb_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);

    // continuous contention from reset, MAX_HOLD=8
    do_reset();
    for (int i = 0; i < 24; i++) begin
      logic e;
      e = (i < 8) || (i >= 16);
      drive(1, 0, 32'h10, 0, 1, 0, 32'h40, 0);
      chk($sformatf("ct_cpu_gnt%0d", i), cpu_gnt, e);
      chk($sformatf("ct_dbg_gnt%0d", i), dbg_gnt, !e);
      chk($sformatf("ct_stall%0d", i), cpu_stall, !e);
    end

    // cpu drops after 3 grants; dbg takes ownership with fresh count
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h10, 0, 1, 0, 32'h40, 0);
      chk($sformatf("dr_pre_cpu%0d", i), cpu_gnt, 1);
    end
    drive(0, 0, 0, 0, 1, 0, 32'h40, 0);
    chk("dr_gap_dbg", dbg_gnt, 1);
    chk("dr_gap_cpu", cpu_gnt, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 32'h10, 0, 1, 0, 32'h40, 0);
      chk($sformatf("dr_dbg_gnt%0d", i), dbg_gnt, i < 8);
      chk($sformatf("dr_cpu_gnt%0d", i), cpu_gnt, i == 8);
    end

    // reset during an outstanding read discards the return
    drive(0, 0, 0, 0, 1, 0, 32'h40, 0);
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("ra_cpu_gnt", cpu_gnt, 1);
    chk("ra_dbg_rvalid_pre", dbg_rvalid, 1);
    rst = 1'b0;
    #1;
    chk("ra_cpu_gnt_rst", cpu_gnt, 0);
    chk("ra_mem_en_rst", mem_en, 0);
    chk("ra_mem_we_rst", mem_we, 0);
    chk("ra_dbg_rvalid_rst", dbg_rvalid, 0);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("ra_cpu_rvalid", cpu_rvalid, 0);
    drive(1, 0, 32'h10, 0, 1, 0, 32'h40, 0);
    chk("ra_owner_cpu", cpu_gnt, 1);
    chk("ra_owner_dbg", dbg_gnt, 0);

    // MAX_HOLD=1 instance alternates strictly
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 32'h10, 0, 1, 0, 32'h40, 0);
      chk($sformatf("alt_cpu%0d", i), u1_cpu_gnt, (i % 2) == 0);
      chk($sformatf("alt_dbg%0d", i), u1_dbg_gnt, (i % 2) == 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter sharing the single unified instruction/data Memory between the multi-cycle CPU datapath (port cpu) and the debug/loader port (port dbg). It selects at most one access per cycle, drives the memory port, and returns read data one cycle later to the winning requester. A starvation-bounded ownership scheme guarantees each contending requester a grant within MAX_HOLD cycles. It drives cpu_stall so CPU_ctrl holds its state while the CPU is denied.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_HOLD, 8, max consecutive contested grants to one owner (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_gnt
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  access issued to memory this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
cpu_stall  out  1  cpu_req & ~cpu_gnt
dbg_req  in  1  debug request, same rules as cpu_req
dbg_we  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  access issued this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DATA_W  debug read data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read issue

Behaviour:
- State: owner (CPU/DBG), hold_cnt (0..MAX_HOLD), rd_pend_cpu, rd_pend_dbg.
- Reset (rst=0, async): owner=CPU, hold_cnt=0, rd_pend_*=0; while rst=0 all gnt, rvalid, mem_en, mem_we =0. Pending read at reset is discarded, never returned.
- Grant decision combinational from req and state; cpu_gnt/dbg_gnt never both 1.
- Only one req: that port granted; next owner=that port, hold_cnt<=0.
- Both req (contested), hold_cnt<MAX_HOLD: owner granted, hold_cnt<=hold_cnt+1.
- Both req, hold_cnt==MAX_HOLD: non-owner granted, owner<=non-owner, hold_cnt<=1.
- No req: no grant, owner and hold_cnt unchanged.
- Memory outputs: mem_en=cpu_gnt|dbg_gnt; mem_we=mem_en & winner's we; mem_addr/mem_wdata muxed from winner; with no grant they carry cpu values, mem_en=mem_we=0.
- Read latency: grant with we=0 sets rd_pend_<port> for next cycle; <port>_rvalid=rd_pend_<port>; both rdata outputs = mem_rdata combinationally (valid only under rvalid).
- Write: completes in the gnt cycle; no rvalid.
- Back-to-back grants allowed every cycle; read issue and previous read return may overlap.
- Requester drops req the cycle after gnt unless issuing another access; req held after gnt is a new request.
- Counter width ceil(log2(MAX_HOLD+1)); saturates, never wraps.

Test Plan:
- Reset, cpu_req=1 read addr 0x10, mem holds 0x1234_5678 -> cpu_gnt same cycle, mem_en=1 mem_we=0 mem_addr=0x10; next cycle cpu_rvalid=1 cpu_rdata=0x12345678; dbg_rvalid=0.
- dbg write addr 0x40 data 0xDEADBEEF, cpu idle -> dbg_gnt=1, mem_we=1, mem_wdata=0xDEADBEEF; no rvalid; later cpu read 0x40 returns 0xDEADBEEF.
- From reset, both req continuously (MAX_HOLD=8) -> grants cycles 0-7 cpu, 8-15 dbg, 16-23 cpu; cpu_stall=1 exactly in 8-15.
- Both req, then cpu drops for one cycle after 3 grants -> dbg wins that cycle, owner=DBG, hold_cnt=0; both resume -> dbg gets next 8 grants.
- cpu read granted, rst pulsed low before next edge -> cpu_rvalid stays 0, all outputs 0 during reset, owner=CPU after release.
- MAX_HOLD=1, both req continuously -> grants strictly alternate cpu, dbg, cpu, dbg.
